// File: rtl/dlx_mem_pkg.sv
// Shared encodings for the DLX data-memory controller: access sizes,
// big-endian lane offsets and the controller FSM states.
package dlx_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Big-endian: byte offset 0 is the most significant lane of the word.
  localparam logic [1:0] OFF_B0 = 2'b00;
  localparam logic [1:0] OFF_B1 = 2'b01;
  localparam logic [1:0] OFF_B2 = 2'b10;
  localparam logic [1:0] OFF_B3 = 2'b11;
  localparam logic [1:0] OFF_H0 = 2'b00;
  localparam logic [1:0] OFF_H2 = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

endpackage

// File: rtl/dlx_mem_ctrl_if.sv
// Bus between the DLX MEM stage / SRAM (master side) and the data-memory
// controller (slave side).
interface dlx_mem_ctrl_if #(parameter int ADDR_WIDTH = 8) ();

  logic                  i_req;
  logic                  i_we;
  logic [31:0]           i_addr;
  logic [1:0]            i_size;
  logic                  i_sign;
  logic [31:0]           i_wdata;
  logic                  o_ack;
  logic                  o_err;
  logic [31:0]           o_rdata;
  logic                  o_busy;
  logic [ADDR_WIDTH-1:0] o_sram_addr;
  logic                  o_sram_write;
  logic [31:0]           o_sram_data;
  logic [31:0]           i_sram_data;

  modport master (
    output i_req, i_we, i_addr, i_size, i_sign, i_wdata, i_sram_data,
    input  o_ack, o_err, o_rdata, o_busy, o_sram_addr, o_sram_write, o_sram_data
  );

  modport slave (
    input  i_req, i_we, i_addr, i_size, i_sign, i_wdata, i_sram_data,
    output o_ack, o_err, o_rdata, o_busy, o_sram_addr, o_sram_write, o_sram_data
  );

endinterface

// File: rtl/dlx_mem_lane.sv
// Combinational lane logic: big-endian load extraction with sign/zero
// extension, and sub-word merge for read-modify-write stores.
module dlx_mem_lane
  import dlx_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      OFF_B0:  b = w[31:24];
      OFF_B1:  b = w[23:16];
      OFF_B2:  b = w[15:8];
      OFF_B3:  b = w[7:0];
      default: b = w[7:0];
    endcase
    case (off & 2'b10)
      OFF_H0:  h = w[31:16];
      OFF_H2:  h = w[15:0];
      default: h = w[15:0];
    endcase
    case (sz)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    case (sz)
      SZ_BYTE: begin
        case (off)
          OFF_B0:  r = {wd[7:0], w[23:0]};
          OFF_B1:  r = {w[31:24], wd[7:0], w[15:0]};
          OFF_B2:  r = {w[31:16], wd[7:0], w[7:0]};
          OFF_B3:  r = {w[31:8], wd[7:0]};
          default: r = w;
        endcase
      end
      SZ_HALF: begin
        case (off & 2'b10)
          OFF_H0:  r = {wd[15:0], w[15:0]};
          OFF_H2:  r = {w[31:16], wd[15:0]};
          default: r = w;
        endcase
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  assign load_data  = extract(word, offset, size, sign);
  assign store_data = merge(word, wdata, offset, size);

endmodule

// File: rtl/dlx_mem_ctrl.sv
// DLX data-memory controller: req/ack handshake, request validation and the
// access FSM driving a single-port SRAM (async read, sync write).
module dlx_mem_ctrl
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  dlx_mem_ctrl_if.slave bus
);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] sram_addr_r;
  logic [1:0]            offset_r;
  logic [1:0]            size_r;
  logic                  we_r;
  logic                  sign_r;
  logic [31:0]           wdata_r;
  logic                  ack_r;
  logic                  err_r;
  logic                  busy_r;
  logic                  sram_write_r;
  logic [31:0]           rdata_r;
  logic [31:0]           sram_data_r;
  logic [31:0]           load_data_s;
  logic [31:0]           store_data_s;

  function automatic logic req_bad(input logic [31:0] addr, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr[1:0] != 2'b00);
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b1;
    endcase
    if ((addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
    return bad;
  endfunction

  dlx_mem_lane u_lane (
    .word       (bus.i_sram_data),
    .wdata      (wdata_r),
    .offset     (offset_r),
    .size       (size_r),
    .sign       (sign_r),
    .load_data  (load_data_s),
    .store_data (store_data_s)
  );

  // Access FSM with all outputs registered; the SRAM is read during ACCESS
  // and written on the edge that ends ACCESS (word) or WRITE (sub-word).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      sram_addr_r  <= '0;
      offset_r     <= 2'b00;
      size_r       <= 2'b00;
      we_r         <= 1'b0;
      sign_r       <= 1'b0;
      wdata_r      <= 32'd0;
      ack_r        <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      sram_write_r <= 1'b0;
      rdata_r      <= 32'd0;
      sram_data_r  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          if (bus.i_req) begin
            sram_addr_r <= bus.i_addr[ADDR_WIDTH+1:2];
            offset_r    <= bus.i_addr[1:0];
            size_r      <= bus.i_size;
            we_r        <= bus.i_we;
            sign_r      <= bus.i_sign;
            wdata_r     <= bus.i_wdata;
            busy_r      <= 1'b1;
            if (req_bad(bus.i_addr, bus.i_size)) begin
              state_r <= ST_ERR;
              ack_r   <= 1'b1;
              err_r   <= 1'b1;
            end else begin
              state_r <= ST_ACCESS;
              // Full-word stores need no read, so write in the ACCESS cycle.
              if (bus.i_we && (bus.i_size == SZ_WORD)) begin
                sram_write_r <= 1'b1;
                sram_data_r  <= bus.i_wdata;
              end else begin
                sram_write_r <= 1'b0;
              end
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (we_r) begin
            if (size_r == SZ_WORD) begin
              sram_write_r <= 1'b0;
              state_r      <= ST_DONE;
            end else begin
              sram_write_r <= 1'b1;
              sram_data_r  <= store_data_s;
              state_r      <= ST_WRITE;
            end
          end else begin
            rdata_r <= load_data_s;
            state_r <= ST_DONE;
          end
        end
        ST_WRITE: begin
          sram_write_r <= 1'b0;
          state_r      <= ST_DONE;
        end
        ST_DONE: begin
          ack_r   <= 1'b1;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_ERR: begin
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ack_r        <= 1'b0;
          err_r        <= 1'b0;
          busy_r       <= 1'b0;
          sram_write_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ack        = ack_r;
  assign bus.o_err        = err_r;
  assign bus.o_rdata      = rdata_r;
  assign bus.o_busy       = busy_r;
  assign bus.o_sram_addr  = sram_addr_r;
  assign bus.o_sram_write = sram_write_r & ~i_rst;
  assign bus.o_sram_data  = sram_data_r;

endmodule

// File: doc/dlx_mem_ctrl.md
Name: dlx_mem_ctrl

Overview:
Data-memory controller between the DLX MEM stage and the single-port 32-bit word SRAM. The SRAM has asynchronous read and synchronous write. The controller accepts byte-addressed load/store requests of byte, halfword or word size through a req/ack handshake. It performs lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores. Misaligned, illegal-size and out-of-range accesses are reported as errors and never touch the SRAM.

Parameters:
ADDR_WIDTH, 8, word-address width of the attached SRAM (depth 2**ADDR_WIDTH words)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
i_req  in  1  request strobe; sampled only in IDLE
i_we  in  1  1 = store, 0 = load
i_addr  in  32  byte address
i_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
i_sign  in  1  loads: 1 = sign-extend, 0 = zero-extend
i_wdata  in  32  store data; sub-word data in the LSBs
o_ack  out  1  one-cycle completion pulse
o_err  out  1  valid with o_ack; 1 = access rejected
o_rdata  out  32  load result; valid with o_ack, held until the next ack
o_busy  out  1  high whenever state != IDLE
o_sram_addr  out  ADDR_WIDTH  word address, equal to i_addr[ADDR_WIDTH+1:2] as latched
o_sram_write  out  1  SRAM write enable
o_sram_data  out  32  SRAM write data
i_sram_data  in  32  SRAM combinational read data

Behaviour:
- Reset values: state IDLE; o_ack=0, o_err=0, o_rdata=0, o_busy=0, o_sram_write=0, o_sram_data=0, o_sram_addr=0; all latched request registers 0.
- o_sram_write is gated with ~i_rst. Reset in any state aborts the operation, returns the controller to IDLE and produces no ack.
- Byte order is big-endian: byte offset 0 occupies bits [31:24] and offset 3 occupies bits [7:0]. Halfword offset 0 occupies [31:16] and offset 2 occupies [15:0].
- FSM states: IDLE, ACCESS, WRITE, DONE, ERR.
- IDLE → (on edge with i_req=1) the controller latches addr, size, we, sign and wdata, then checks the request:
  - error if size==11;
  - error if size==01 and addr[0]!=0;
  - error if size==10 and addr[1:0]!=0;
  - error if addr[31:ADDR_WIDTH+2]!=0.
  - Error → ERR; otherwise → ACCESS.
- ERR: o_ack=1, o_err=1, o_rdata unchanged; → IDLE.
- ACCESS: o_sram_addr driven from the latched address.
  - Load: extract the lane from i_sram_data, extend it per the latched sign, register into o_rdata; → DONE.
  - Word store: o_sram_write=1, o_sram_data=wdata; → DONE.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into i_sram_data at the lane and register the merged word; → WRITE.
- WRITE: o_sram_write=1, o_sram_data=merged word; → DONE.
- DONE: o_ack=1, o_err=0; → IDLE.
- Latency, counted from the accepting edge k, gives the cycle in which o_ack is high:
  - error: after edge k (1 cycle);
  - load or word store: after edge k+2;
  - byte/halfword store: after edge k+3.
- i_req is ignored while busy and no queueing is performed. A new request can be accepted at the first edge after the ack cycle, so back-to-back throughput is one access per 3 or 4 cycles.
- o_sram_write is never asserted outside ACCESS or WRITE. It is asserted at most once per accepted request.
- The SRAM write occurs at the edge ending ACCESS or WRITE, so a following load observes the new data.

Decomposition:
- Package dlx_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state encoding;
  - lane-offset constants.
- Sub-module dlx_mem_lane is purely combinational and provides two functions:
  - extract(word, offset, size, sign) → 32-bit load value;
  - merge(word, wdata, offset, size) → 32-bit store word.
- The FSM, handshake and error checks stay in dlx_mem_ctrl.

Test Plan:
- Word store 0xDEADBEEF to addr 0x10, then word load 0x10 → acks 2 cycles after each accept, o_err=0, o_rdata=0xDEADBEEF, SRAM[4]=0xDEADBEEF.
- With SRAM[4]=0x11223344: byte store 0xAA to 0x11, then half store 0x5566 to 0x12 → SRAM[4]=0x11AA5566; each store gives exactly one o_sram_write pulse; ack arrives 3 cycles after accept.
- With SRAM[4]=0x80FF7F01:
  - signed byte load 0x10 → 0xFFFFFF80;
  - unsigned byte load 0x10 → 0x00000080;
  - signed half load 0x12 → 0x00007F01;
  - signed half load 0x10 → 0xFFFF80FF.
- Errors: half load at 0x13, word store at 0x102, size=11, and addr=0x400 (ADDR_WIDTH=8) → each acks 1 cycle after accept with o_err=1, no o_sram_write, and o_rdata unchanged.
- i_rst asserted during WRITE of a byte store to 0x10 with SRAM[4]=0x11223344 → SRAM[4] unchanged, no ack, IDLE next cycle with all outputs at reset values.
- i_req held high continuously with alternating store/load → every accept occurs only in IDLE, exactly one ack per accepted request, and no request is accepted while o_busy=1.
